// File: rtl/reduce_ingress_tagger.sv
// reduce_ingress_tagger: tags reduction flits with binomial-tree children count into a show-ahead FIFO; REDUCE_BYPASS_EN forwards non-reduction flits
module reduce_ingress_tagger #(
  parameter logic [8:0] my_rank = 9'd0,
  parameter int lg_numprocs = 3,
  parameter int PayloadWidth = 32,
  parameter int FifoDepth = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [PayloadWidth+49:0] flit_in,
  output logic in_ready,
  output logic [PayloadWidth+lg_numprocs+49:0] packetA,
  output logic [12:0] fifo_counter,
  output logic buf_empty,
  output logic buf_full,
  input  logic rd_en,
  output logic [PayloadWidth+49:0] bypass_out,
  output logic bypass_valid
);
  localparam int FW = PayloadWidth + 50;
  localparam int TW = FW + lg_numprocs;
  localparam int AW = $clog2(FifoDepth);
  logic [TW-1:0] mem [FifoDepth];
  logic [TW-1:0] stage;
  logic stage_valid;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [lg_numprocs-1:0] rel, ch;
  logic is_red, wr, pop;
  always_comb begin
    rel = lg_numprocs'(my_rank - flit_in[62:54]);
    ch = lg_numprocs'(lg_numprocs);
    for (int i = lg_numprocs - 1; i >= 0; i--) ch = rel[i] ? lg_numprocs'(i) : ch;
  end
  assign is_red = flit_in[FW-1] && flit_in[35:34] == 2'b11;
  assign buf_empty = fifo_counter == 13'd0;
  assign buf_full = fifo_counter == 13'(FifoDepth);
  assign wr = stage_valid && !buf_full;
  assign pop = rd_en && !buf_empty;
  assign packetA = buf_empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_valid <= 1'b0;
      stage <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_counter <= '0;
    end else begin
      if (is_red && !(stage_valid && buf_full)) begin
        stage_valid <= 1'b1;
        stage <= {ch, flit_in};
      end else if (wr) stage_valid <= 1'b0;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_counter <= fifo_counter + 13'(wr) - 13'(pop);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wr_ptr] <= stage;
`ifdef REDUCE_BYPASS_EN
  logic is_byp;
  assign is_byp = flit_in[FW-1] && !is_red;
  assign in_ready = !(stage_valid && buf_full) || is_byp;
  always_ff @(posedge clk) begin
    if (!rst) begin
      bypass_valid <= 1'b0;
      bypass_out <= '0;
    end else begin
      bypass_valid <= is_byp;
      if (is_byp) bypass_out <= flit_in;
    end
  end
`else
  assign in_ready = !(stage_valid && buf_full);
  assign bypass_out = '0;
  assign bypass_valid = 1'b0;
`endif
endmodule

// File: tb/tb_reduce_ingress_tagger.sv
// tb_reduce_ingress_tagger: directed self-checking bench for reduce_ingress_tagger
module tb_reduce_ingress_tagger;
  logic clk = 0, rst = 0, rd_en = 0;
  logic [81:0] flit_in = '0;
  logic in_ready, buf_empty, buf_full, bypass_valid;
  logic [84:0] packetA;
  logic [12:0] fifo_counter;
  logic [81:0] bypass_out;
  logic [81:0] fa, fb, fc, fd, fn;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  reduce_ingress_tagger dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .in_ready(in_ready), .packetA(packetA),
    .fifo_counter(fifo_counter), .buf_empty(buf_empty), .buf_full(buf_full), .rd_en(rd_en),
    .bypass_out(bypass_out), .bypass_valid(bypass_valid)
  );
  task automatic check(input string tag, input logic [84:0] got, input logic [84:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [81:0] mk(input logic [8:0] root, input logic [3:0] op, input logic [31:0] pay);
    logic [81:0] f;
    f = '0;
    f[81] = 1'b1;
    f[80:63] = 18'h2A5A5;
    f[62:54] = root;
    f[35:32] = op;
    f[31:0] = pay;
    return f;
  endfunction
  initial begin
    fa = mk(9'd0, 4'hC, 32'hA);
    fb = mk(9'd4, 4'hC, 32'hB);
    fc = mk(9'd6, 4'hD, 32'hC);
    fd = mk(9'd5, 4'hF, 32'hD);
    fn = mk(9'd0, 4'h7, 32'h77);
    flit_in = fa;
    rd_en = 1;
    tick;
    tick;
    check("rst_empty", 85'(buf_empty), 85'd1);
    check("rst_cnt", 85'(fifo_counter), 85'd0);
    check("rst_pkt", packetA, 85'd0);
    check("rst_byp", 85'(bypass_valid), 85'd0);
    check("rst_full", 85'(buf_full), 85'd0);
    check("rst_rdy", 85'(in_ready), 85'd1);
    flit_in = '0;
    rd_en = 0;
    rst = 1;
    tick;
    tick;
    check("post_rst_cnt", 85'(fifo_counter), 85'd0);
    flit_in = fa;
    tick;
    check("lat_stage", 85'(buf_empty), 85'd1);
    flit_in = fb;
    tick;
    check("lat_head", packetA, {3'd3, fa});
    flit_in = fc;
    tick;
    flit_in = fd;
    tick;
    flit_in = '0;
    tick;
    check("tag_cnt", 85'(fifo_counter), 85'd4);
    check("tag_r0", packetA, {3'd3, fa});
    rd_en = 1;
    tick;
    check("tag_r4", packetA, {3'd2, fb});
    tick;
    check("tag_r6", packetA, {3'd1, fc});
    tick;
    check("tag_r5", packetA, {3'd0, fd});
    tick;
    rd_en = 0;
    check("tag_drained", 85'(fifo_counter), 85'd0);
    check("tag_pkt0", packetA, 85'd0);
    for (int i = 0; i < 17; i++) begin
      flit_in = mk(9'd0, 4'hC, 32'(i));
      check("fill_rdy", 85'(in_ready), 85'd1);
      tick;
    end
    flit_in = mk(9'd0, 4'hC, 32'd99);
    check("fill_cnt", 85'(fifo_counter), 85'd16);
    check("fill_full", 85'(buf_full), 85'd1);
    check("fill_stall", 85'(in_ready), 85'd0);
    tick;
    tick;
    check("fill_hold_cnt", 85'(fifo_counter), 85'd16);
    check("fill_head", packetA, {3'd3, mk(9'd0, 4'hC, 32'd0)});
    flit_in = '0;
    rd_en = 1;
    tick;
    rd_en = 0;
    check("fill_pop_cnt", 85'(fifo_counter), 85'd15);
    tick;
    check("fill_drain_cnt", 85'(fifo_counter), 85'd16);
    check("fill_rdy_back", 85'(in_ready), 85'd1);
    rd_en = 1;
    for (int i = 1; i < 17; i++) begin
      check("fill_order", packetA, {3'd3, mk(9'd0, 4'hC, 32'(i))});
      tick;
    end
    rd_en = 0;
    check("fill_empty", 85'(buf_empty), 85'd1);
    for (int i = 0; i < 6; i++) begin
      flit_in = mk(9'd4, 4'hC, 32'(100 + i));
      tick;
    end
    check("pp_start", 85'(fifo_counter), 85'd5);
    rd_en = 1;
    for (int j = 0; j < 10; j++) begin
      flit_in = mk(9'd4, 4'hC, 32'(106 + j));
      check("pp_head", packetA, {3'd2, mk(9'd4, 4'hC, 32'(100 + j))});
      tick;
      check("pp_cnt", 85'(fifo_counter), 85'd5);
    end
    rd_en = 0;
    flit_in = '0;
    tick;
    check("pp_tail_cnt", 85'(fifo_counter), 85'd6);
    rd_en = 1;
    for (int j = 0; j < 6; j++) begin
      check("pp_tail", packetA, {3'd2, mk(9'd4, 4'hC, 32'(110 + j))});
      tick;
    end
    tick;
    tick;
    check("uf_cnt", 85'(fifo_counter), 85'd0);
    check("uf_pkt", packetA, 85'd0);
    check("uf_empty", 85'(buf_empty), 85'd1);
    rd_en = 0;
    flit_in = fd;
    tick;
    flit_in = '0;
    tick;
    check("uf_recover_cnt", 85'(fifo_counter), 85'd1);
    check("uf_recover_pkt", packetA, {3'd0, fd});
    rd_en = 1;
    tick;
    rd_en = 0;
    flit_in = fn;
    tick;
`ifdef REDUCE_BYPASS_EN
    check("byp_valid", 85'(bypass_valid), 85'd1);
    check("byp_data", 85'(bypass_out), 85'(fn));
`else
    check("byp_valid", 85'(bypass_valid), 85'd0);
    check("byp_data", 85'(bypass_out), 85'd0);
`endif
    flit_in = fa;
    flit_in[81] = 1'b0;
    tick;
    check("byp_one_cycle", 85'(bypass_valid), 85'd0);
    flit_in = '0;
    tick;
    check("byp_fifo_cnt", 85'(fifo_counter), 85'd0);
    flit_in = fa;
    tick;
    flit_in = fb;
    tick;
    flit_in = fc;
    tick;
    flit_in = '0;
    rst = 0;
    tick;
    check("mid_rst_cnt", 85'(fifo_counter), 85'd0);
    check("mid_rst_pkt", packetA, 85'd0);
    rst = 1;
    tick;
    tick;
    check("mid_rst_stage", 85'(fifo_counter), 85'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reduce_ingress_tagger.md
Name: reduce_ingress_tagger

Overview:
- Ingress stage directly upstream of the reduction unit.
- Accepts 82-bit network flits and classifies them as reduction or non-reduction.
- Tags each reduction flit with its binomial-tree children count and buffers the 85-bit result in a show-ahead FIFO.
- Exposes FIFO head, occupancy, empty and full to the reduction unit, which pops via rd_en. Non-reduction flits leave on a bypass port (optional feature).

Parameters:
- my_rank, 9'd0, linear rank of this node, compared against the root in the flit rank field.
- lg_numprocs, 3, log2 of node count; children width = lg_numprocs.
- PayloadWidth, 32, payload width; flit layout as codebase (valid at bit 81).
- FifoDepth, 16, FIFO entries; power of two, 2..4096.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- flit_in  in  82  incoming flit; flit_in[81] is its valid bit.
- in_ready  out  1  flit_in accepted this cycle when flit_in[81]=1 and in_ready=1.
- packetA  out  85  FIFO head: {children[84:82], flit[81:0]}; all zeros when empty.
- fifo_counter  out  13  FIFO occupancy.
- buf_empty  out  1  fifo_counter==0.
- buf_full  out  1  fifo_counter==FifoDepth.
- rd_en  in  1  pop head at clock edge; ignored when empty.
- bypass_out  out  82  non-reduction flit, registered.
- bypass_valid  out  1  bypass_out valid this cycle.

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO pointers, fifo_counter and the stage register are cleared.
  - bypass_valid=0, bypass_out=0, packetA=0, buf_empty=1, buf_full=0, in_ready=1.
  - Reset mid-operation discards all buffered flits with no partial outputs.
- Classification:
  - Reduction flit: flit_in[81]=1 and op[35:34]==2'b11.
  - Any other flit with flit_in[81]=1 is non-reduction.
- Children count:
  - root = flit_in[62:54].
  - rel = (my_rank - root) mod 2^lg_numprocs.
  - children = count of trailing zeros of rel; rel=0 gives lg_numprocs.
  - Computed combinationally on flit_in, then registered.
- Tag stage (1 register):
  - Holds stage_valid and the 85-bit tagged flit.
  - Loads on an accepted reduction flit.
  - in_ready = !(stage_valid && buf_full).
  - Stage drains to the FIFO whenever stage_valid && !buf_full.
  - Holds while full; the upstream flit stalls.
- FIFO:
  - Write = stage drain. Pop = rd_en && !buf_empty.
  - Simultaneous write and pop: count unchanged, both pointers advance.
  - Write at full never occurs, because the stage holds.
  - Pointers wrap modulo FifoDepth.
- Latency: reduction flit accepted at edge N is in the stage after N, in the FIFO after N+1, and visible on packetA during cycle N+2 when the FIFO was empty.
- packetA is combinational from the head entry, gated to zero when empty. The reduction unit sees bit 81=0 when no data.
- Ordering preserved. No duplicate filtering. Flits with flit_in[81]=0 are ignored regardless of other bits.

Optional Feature:
- Macro: REDUCE_BYPASS_EN.
- Defined:
  - An accepted non-reduction flit is registered to bypass_out with bypass_valid=1 for exactly one cycle.
  - Non-reduction flits never stall: in_ready gating applies only to reduction flits.
  - bypass_valid deasserts the next cycle unless another non-reduction flit is accepted.
- Undefined:
  - Non-reduction flits are accepted and discarded.
  - bypass_out=0 and bypass_valid=0 constantly.

Test Plan:
- Reset: rst=0 for 2 cycles with traffic present -> buf_empty=1, fifo_counter=0, packetA=0, bypass_valid=0.
- Tagging, my_rank=0, lg_numprocs=3:
  - Reduction flits with root 0, 4, 6, 5 -> children 3, 2, 1, 0 respectively.
  - Each appears on packetA two cycles after acceptance, in order.
- Fill: rd_en=0, stream 17 reduction flits with FifoDepth=16 -> buf_full=1 at count 16; 17th held in the stage; in_ready=0 thereafter.
  - Then assert rd_en for one cycle -> stage drains, count stays 16, in_ready returns 1.
- Simultaneous push/pop at count 5 for 10 cycles -> fifo_counter constant 5, data order intact, pointer wrap exercised.
- Pop when empty: rd_en=1 with FIFO empty -> fifo_counter stays 0, no underflow, packetA=0.
- With REDUCE_BYPASS_EN: non-reduction flit (op=4'b0111) -> bypass_valid=1 for 1 cycle with flit unchanged, FIFO untouched.
  - Without the macro: same flit -> no output, fifo_counter unchanged.
